// File: rtl/gate_model_bist_if.sv
// Bus between the test sequencer and the gate-model BIST driver.
//   start     : single-cycle run request (sequencer -> BIST)
//   response  : 10 model outputs, bit 0 = first output in the model's list
//   pattern   : 22 model inputs, bit 0 = N1, bit 21 = N22
//   busy/done : run status
//   signature : MISR contents
//   pass      : run complete and signature matched the golden value
interface gate_model_bist_if;
  logic        start;
  logic [9:0]  response;
  logic [21:0] pattern;
  logic        busy;
  logic        done;
  logic [15:0] signature;
  logic        pass;

  modport slave (
    input  start, response,
    output pattern, busy, done, signature, pass
  );

  modport master (
    output start, response,
    input  pattern, busy, done, signature, pass
  );
endinterface

// File: rtl/gate_model_bist.sv
// BIST driver and response compactor for 22-input / 10-output gate models.
// A 22-bit LFSR (x^22+x^21+1) drives the model inputs; each pattern is held
// for SETTLE_CYC cycles and the model response is folded into a 16-bit MISR
// (CRC-CCITT feedback 0x1021) on the last cycle of the hold. After PATTERNS
// captures the block reports done, the signature, and pass = (sig == GOLDEN).
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous, active-high reset
//   bus  : gate_model_bist_if.slave (start, response, pattern, busy, done,
//          signature, pass)
// Every output is decoded from registers; no input reaches an output
// combinationally.
module gate_model_bist #(
  parameter int          PATTERNS   = 256,
  parameter int          SETTLE_CYC = 2,
  parameter logic [21:0] SEED       = 22'h000001,
  parameter logic [15:0] GOLDEN     = 16'h0000
) (
  input  logic              clk,
  input  logic              rst,
  gate_model_bist_if.slave  bus
);

  localparam int CW = $clog2(PATTERNS + 1);
  localparam int SW = $clog2(SETTLE_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(PATTERNS - 1);
  localparam logic [SW-1:0] SCNT_LAST = SW'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_t;

  state_t         state, state_nxt;
  logic [21:0]    lfsr;
  logic [15:0]    misr;
  logic [CW-1:0]  cnt;
  logic [SW-1:0]  scnt;
  logic           pass_r;
  logic           launch;
  logic           capture;
  logic [15:0]    misr_nxt;

  function automatic logic [21:0] lfsr_step(input logic [21:0] v);
    return {v[20:0], v[21] ^ v[20]};
  endfunction

  function automatic logic [15:0] misr_step(input logic [15:0] m,
                                            input logic [9:0]  r);
    return {m[14:0], 1'b0} ^ (m[15] ? 16'h1021 : 16'h0000) ^ {6'b0, r};
  endfunction

  assign misr_nxt = misr_step(misr, bus.response);

  // Control: next state, launch of a run, capture strobe
  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          launch    = 1'b1;
          state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        // start is deliberately not looked at here: a run cannot be
        // interrupted except by rst.
        if (scnt == SCNT_LAST) begin
          capture = 1'b1;
          if (cnt == CNT_LAST) state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Datapath: LFSR, MISR, counters and registered pass flag
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr   <= SEED;
      misr   <= 16'h0000;
      cnt    <= '0;
      scnt   <= '0;
      pass_r <= 1'b0;
    end else if (launch) begin
      lfsr   <= SEED;
      misr   <= 16'h0000;
      cnt    <= '0;
      scnt   <= '0;
      pass_r <= 1'b0;
    end else if (state == SETTLE) begin
      if (capture) begin
        misr <= misr_nxt;
        lfsr <= lfsr_step(lfsr);
        scnt <= '0;
        cnt  <= cnt + CW'(1);
        // Compare against the value being written so pass is valid on the
        // same edge that enters DONE.
        if (cnt == CNT_LAST) pass_r <= (misr_nxt == GOLDEN);
      end else begin
        scnt <= scnt + SW'(1);
      end
    end
  end

  assign bus.pattern   = lfsr;
  assign bus.signature = misr;
  assign bus.busy      = (state == SETTLE);
  assign bus.done      = (state == DONE);
  assign bus.pass      = pass_r;

endmodule

// File: tb/tb_gate_model_bist.sv
module tb_gate_model_bist;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gate_model_bist_if i1a ();
  gate_model_bist_if i1b ();
  gate_model_bist_if i2 ();
  gate_model_bist_if i3 ();

  gate_model_bist #(.PATTERNS(1), .SETTLE_CYC(1), .GOLDEN(16'h03FF))
    u1a (.clk(clk), .rst(rst), .bus(i1a.slave));
  gate_model_bist #(.PATTERNS(1), .SETTLE_CYC(1), .GOLDEN(16'h0000))
    u1b (.clk(clk), .rst(rst), .bus(i1b.slave));
  gate_model_bist #(.PATTERNS(2), .SETTLE_CYC(1), .GOLDEN(16'h0401))
    u2 (.clk(clk), .rst(rst), .bus(i2.slave));
  gate_model_bist #(.PATTERNS(4), .SETTLE_CYC(3), .GOLDEN(16'h1FF9))
    u3 (.clk(clk), .rst(rst), .bus(i3.slave));

  typedef struct {
    logic        start;
    logic [9:0]  resp;
    logic [21:0] pat;
    logic [15:0] sig;
    logic        busy;
    logic        done;
    logic        pass;
  } vec_t;

  vec_t tbl [1:12];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One full run of u3 (4 patterns, 3 cycles each), started at edge 0.
  // Entry i holds what is driven before edge i and what must be seen after.
  task automatic run_u3(input string tag);
    i3.start    = 1'b1;
    i3.response = 10'h000;
    @(posedge clk); #1;
    i3.start = 1'b0;
    chk({tag, "_launch_busy"}, 32'(i3.busy), 'h1);
    chk({tag, "_launch_done"}, 32'(i3.done), 'h0);
    chk({tag, "_launch_pat"},  32'(i3.pattern), 'h1);
    chk({tag, "_launch_sig"},  32'(i3.signature), 'h0);
    for (int i = 1; i <= 12; i++) begin
      i3.start    = tbl[i].start;
      i3.response = tbl[i].resp;
      @(posedge clk); #1;
      chk($sformatf("%s_pat%0d", tag, i),  32'(i3.pattern),   32'(tbl[i].pat));
      chk($sformatf("%s_sig%0d", tag, i),  32'(i3.signature), 32'(tbl[i].sig));
      chk($sformatf("%s_busy%0d", tag, i), 32'(i3.busy),      32'(tbl[i].busy));
      chk($sformatf("%s_done%0d", tag, i), 32'(i3.done),      32'(tbl[i].done));
      chk($sformatf("%s_pass%0d", tag, i), 32'(i3.pass),      32'(tbl[i].pass));
    end
    i3.start = 1'b0;
  endtask

  initial begin
    // Captures at edges 3,6,9,12 see 3FF,155,2AA,001:
    //   0 -> 03FF -> 06AB -> 0FFC -> 1FF9
    // Other entries drive junk responses that must not be captured; start
    // is raised mid-run at edges 4 and 9 and must be ignored.
    tbl[1]  = '{1'b0, 10'h0F0, 22'h000001, 16'h0000, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 10'h30C, 22'h000001, 16'h0000, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 10'h3FF, 22'h000002, 16'h03FF, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 10'h000, 22'h000002, 16'h03FF, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 10'h2AA, 22'h000002, 16'h03FF, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 10'h155, 22'h000004, 16'h06AB, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 10'h3FF, 22'h000004, 16'h06AB, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 10'h0F0, 22'h000004, 16'h06AB, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 10'h2AA, 22'h000008, 16'h0FFC, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 10'h155, 22'h000008, 16'h0FFC, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 10'h3FF, 22'h000008, 16'h0FFC, 1'b1, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 10'h001, 22'h000010, 16'h1FF9, 1'b0, 1'b1, 1'b1};

    i1a.start = 1'b0; i1a.response = 10'h000;
    i1b.start = 1'b0; i1b.response = 10'h000;
    i2.start  = 1'b0; i2.response  = 10'h000;
    i3.start  = 1'b0; i3.response  = 10'h000;

    // Reset values
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_pat",  32'(i3.pattern),   'h1);
    chk("rst_sig",  32'(i3.signature), 'h0);
    chk("rst_busy", 32'(i3.busy),      'h0);
    chk("rst_done", 32'(i3.done),      'h0);
    chk("rst_pass", 32'(i3.pass),      'h0);
    chk("rst_pass_1a", 32'(i1a.pass),  'h0);
    chk("rst_sig_2",   32'(i2.signature), 'h0);

    // Single pattern, two golden values
    i1a.response = 10'h3FF; i1b.response = 10'h3FF;
    i1a.start = 1'b1;       i1b.start = 1'b1;
    @(posedge clk); #1;
    i1a.start = 1'b0;       i1b.start = 1'b0;
    chk("p1_busy", 32'(i1a.busy),    'h1);
    chk("p1_pat",  32'(i1a.pattern), 'h1);
    @(posedge clk); #1;
    chk("p1_sig",     32'(i1a.signature), 'h3FF);
    chk("p1_done",    32'(i1a.done),      'h1);
    chk("p1_busyoff", 32'(i1a.busy),      'h0);
    chk("p1_pass_g",  32'(i1a.pass),      'h1);
    chk("p1_pass_0",  32'(i1b.pass),      'h0);
    chk("p1_sig_b",   32'(i1b.signature), 'h3FF);

    // Two patterns
    i2.response = 10'h3FF;
    i2.start = 1'b1;
    @(posedge clk); #1;
    i2.start = 1'b0;
    chk("p2_pat0",  32'(i2.pattern),   'h1);
    @(posedge clk); #1;
    chk("p2_pat1",  32'(i2.pattern),   'h2);
    chk("p2_sig1",  32'(i2.signature), 'h3FF);
    chk("p2_done1", 32'(i2.done),      'h0);
    @(posedge clk); #1;
    chk("p2_sig2",  32'(i2.signature), 'h401);
    chk("p2_done2", 32'(i2.done),      'h1);
    chk("p2_pass",  32'(i2.pass),      'h1);

    // Settle timing, ignored mid-run start, then restart from DONE
    run_u3("run1");
    run_u3("rerun");

    // Mid-run reset together with start
    i3.start = 1'b1;
    @(posedge clk); #1;
    i3.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("mid_busy_before", 32'(i3.busy), 'h1);
    rst = 1'b1;
    i3.start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    i3.start = 1'b0;
    chk("mrst_busy", 32'(i3.busy),      'h0);
    chk("mrst_done", 32'(i3.done),      'h0);
    chk("mrst_pass", 32'(i3.pass),      'h0);
    chk("mrst_pat",  32'(i3.pattern),   'h1);
    chk("mrst_sig",  32'(i3.signature), 'h0);
    @(posedge clk); #1;
    chk("mrst_idle_busy", 32'(i3.busy), 'h0);
    chk("mrst_idle_pat",  32'(i3.pattern), 'h1);
    run_u3("postrst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
